// File: rtl/alu_tile_router.sv
// Five-port mesh tile router: per-input FIFOs, XY routing, round-robin output arbiters, registered local ALU.
// Optional multiplier for opcode 8 enabled by defining ALU_TILE_MUL_EN.

module alu_tile_router_fifo #(
    parameter int W     = 144,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
endmodule

module alu_tile_router #(
    parameter int DATA_W       = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int COORD_W      = 4,
    parameter int PARTITION_ID = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COORD_W-1:0]     tile_x,
    input  logic [COORD_W-1:0]     tile_y,
    input  logic [4:0][DATA_W-1:0] in_a,
    input  logic [4:0][DATA_W-1:0] in_b,
    input  logic [4:0][15:0]       in_ctrl,
    input  logic [4:0]             in_valid,
    output logic [4:0]             in_ready,
    output logic [3:0][DATA_W-1:0] out_a,
    output logic [3:0][DATA_W-1:0] out_b,
    output logic [3:0][15:0]       out_ctrl,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [DATA_W-1:0]      host_out_a,
    output logic [15:0]            host_out_ctrl,
    output logic                   host_out_valid,
    input  logic                   host_out_ready
);
    localparam int NP  = 5;
    localparam int CW  = (COORD_W < 4) ? COORD_W : 4;
    localparam int SHW = $clog2(DATA_W);

    typedef struct packed {
        logic [15:0]       ctrl;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } flit_t;

    // Partition tag is carried for system bookkeeping only.
    if (PARTITION_ID < 0) begin : g_partition_tag
    end

    flit_t           in_flit [NP];
    flit_t           head    [NP];
    flit_t           hf;
    logic [NP-1:0]   empty, full, push, pop, slot_free, gnt;
    logic [NP-1:0][2:0] route, win, rr_ptr;
    logic [DATA_W-1:0]  alu_res;

    function automatic logic [2:0] xy_route(input logic [15:0] ctrl,
                                            input logic [CW-1:0] tx,
                                            input logic [CW-1:0] ty);
        logic [CW-1:0] dx, dy;
        dx = ctrl[12 +: CW];
        dy = ctrl[8 +: CW];
        if (dx > tx)      return 3'd1;
        else if (dx < tx) return 3'd3;
        else if (dy > ty) return 3'd2;
        else if (dy < ty) return 3'd0;
        else              return 3'd4;
    endfunction

    assign in_ready = ~full & {NP{~rst}};
    assign push     = in_valid & in_ready;

    for (genvar i = 0; i < NP; i++) begin : g_in
        assign in_flit[i] = '{ctrl: in_ctrl[i], b: in_b[i], a: in_a[i]};
        alu_tile_router_fifo #(.W($bits(flit_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .wdata (in_flit[i]),
            .pop   (pop[i]),
            .rdata (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
        assign route[i] = xy_route(head[i].ctrl, tile_x[CW-1:0], tile_y[CW-1:0]);
    end

    assign slot_free[3:0] = ~out_valid | out_ready;
    assign slot_free[4]   = ~host_out_valid | host_out_ready;

    // Each output searches inputs starting one past its previous winner.
    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        win = '0;
        for (int o = 0; o < NP; o++) begin
            for (int k = 1; k <= NP; k++) begin
                idx = (int'(rr_ptr[o]) + k) % NP;
                if (!gnt[o] && slot_free[o] && !empty[idx] && route[idx] == 3'(o)) begin
                    gnt[o] = 1'b1;
                    win[o] = 3'(idx);
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++)
            if (gnt[o]) pop[win[o]] = 1'b1;
    end

    assign hf = head[win[4]];

    always_comb begin
        alu_res = '0;
        case (hf.ctrl[7:4])
            4'd0: alu_res = hf.a + hf.b;
            4'd1: alu_res = hf.a - hf.b;
            4'd2: alu_res = hf.a & hf.b;
            4'd3: alu_res = hf.a | hf.b;
            4'd4: alu_res = hf.a ^ hf.b;
            4'd5: alu_res = hf.a << hf.b[SHW-1:0];
            4'd6: alu_res = hf.a >> hf.b[SHW-1:0];
            4'd7: alu_res = hf.a;
`ifdef ALU_TILE_MUL_EN
            4'd8: alu_res = hf.a * hf.b;
`endif
            default: alu_res = '0;
        endcase
    end

    // Slots only load on a grant, so a stalled slot keeps its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= '0;
            out_a          <= '0;
            out_b          <= '0;
            out_ctrl       <= '0;
            host_out_valid <= 1'b0;
            host_out_a     <= '0;
            host_out_ctrl  <= '0;
            rr_ptr         <= '0;
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (gnt[o]) begin
                    out_valid[o] <= 1'b1;
                    out_a[o]     <= head[win[o]].a;
                    out_b[o]     <= head[win[o]].b;
                    out_ctrl[o]  <= head[win[o]].ctrl;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            if (gnt[4]) begin
                host_out_valid <= 1'b1;
                host_out_a     <= alu_res;
                host_out_ctrl  <= hf.ctrl;
            end else if (host_out_ready) begin
                host_out_valid <= 1'b0;
            end
            for (int o = 0; o < NP; o++)
                if (gnt[o]) rr_ptr[o] <= win[o];
        end
    end
endmodule

// File: tb/tb_alu_tile_router.sv
// Directed plus random bench for alu_tile_router against a queue-based reference model.

module tb_alu_tile_router;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int TX    = 2;
    localparam int TY    = 2;
`ifdef ALU_TILE_MUL_EN
    localparam logic [63:0] MUL_EXP = 64'd12;
`else
    localparam logic [63:0] MUL_EXP = 64'd0;
`endif

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [15:0] ctrl;
    } flit_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         tile_x = 4'(TX);
    logic [3:0]         tile_y = 4'(TY);
    logic [4:0][DW-1:0] in_a, in_b;
    logic [4:0][15:0]   in_ctrl;
    logic [4:0]         in_valid;
    logic [4:0]         in_ready;
    logic [3:0][DW-1:0] out_a, out_b;
    logic [3:0][15:0]   out_ctrl;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [DW-1:0]      host_out_a;
    logic [15:0]        host_out_ctrl;
    logic               host_out_valid;
    logic               host_out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    flit_t mq [5][$];
    flit_t ms [5];
    bit    mv [5];
    int    mptr [5];

    always #5 clk = ~clk;

    alu_tile_router #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .COORD_W(4), .PARTITION_ID(0)) dut (
        .clk(clk), .rst(rst), .tile_x(tile_x), .tile_y(tile_y),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .host_out_a(host_out_a), .host_out_ctrl(host_out_ctrl), .host_out_valid(host_out_valid),
        .host_out_ready(host_out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Destination output: 0=N 1=E 2=S 3=W 4=local
    function automatic int ref_route(input logic [15:0] ctrl);
        int dx, dy;
        dx = int'(ctrl[15:12]);
        dy = int'(ctrl[11:8]);
        if (dx > TX) return 1;
        if (dx < TX) return 3;
        if (dy > TY) return 2;
        if (dy < TY) return 0;
        return 4;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << (b % 64);
            4'd6: return a >> (b % 64);
            4'd7: return a;
            4'd8: return MUL_EXP == 64'd0 ? 64'd0 : a * b;
            default: return 64'd0;
        endcase
    endfunction

    // Advance the reference model by one clock using the inputs currently driven.
    task automatic model_edge();
        bit [4:0] rdy;
        bit       g [5];
        int       w [5];
        bit       free;
        int       idx;
        flit_t    f;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                mq[i].delete();
                mv[i] = 0;
                ms[i] = '0;
                mptr[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 5; i++) rdy[i] = mq[i].size() < DEPTH;
        for (int o = 0; o < 5; o++) begin
            g[o] = 0;
            w[o] = 0;
            free = !mv[o] || (o < 4 ? out_ready[o] : host_out_ready);
            if (free) begin
                for (int k = 1; k <= 5; k++) begin
                    idx = (mptr[o] + k) % 5;
                    if (!g[o] && mq[idx].size() > 0 && ref_route(mq[idx][0].ctrl) == o) begin
                        g[o] = 1;
                        w[o] = idx;
                    end
                end
                if (!g[o]) mv[o] = 0;
            end
        end
        for (int o = 0; o < 5; o++) begin
            if (g[o]) begin
                f = mq[w[o]].pop_front();
                if (o < 4) ms[o] = f;
                else ms[4] = '{a: ref_alu(f.ctrl[7:4], f.a, f.b), b: 64'd0, ctrl: f.ctrl};
                mv[o] = 1;
                mptr[o] = w[o];
            end
        end
        for (int i = 0; i < 5; i++)
            if (in_valid[i] && rdy[i])
                mq[i].push_back('{a: in_a[i], b: in_b[i], ctrl: in_ctrl[i]});
    endtask

    task automatic check_all();
        for (int o = 0; o < 4; o++) begin
            chk($sformatf("out_valid[%0d]", o), 64'(out_valid[o]), 64'(mv[o]));
            chk($sformatf("out_a[%0d]", o), out_a[o], ms[o].a);
            chk($sformatf("out_b[%0d]", o), out_b[o], ms[o].b);
            chk($sformatf("out_ctrl[%0d]", o), 64'(out_ctrl[o]), 64'(ms[o].ctrl));
        end
        chk("host_out_valid", 64'(host_out_valid), 64'(mv[4]));
        chk("host_out_a", host_out_a, ms[4].a);
        chk("host_out_ctrl", 64'(host_out_ctrl), 64'(ms[4].ctrl));
        for (int i = 0; i < 5; i++)
            chk($sformatf("in_ready[%0d]", i), 64'(in_ready[i]),
                64'(!rst && mq[i].size() < DEPTH));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic offer(input int p, input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
        in_valid[p] = 1'b1;
        in_a[p]     = a;
        in_b[p]     = b;
        in_ctrl[p]  = c;
    endtask

    function automatic logic [3:0] rr_next(input logic [3:0] prev);
        case (prev)
            4'd0: return 4'd2;
            4'd2: return 4'd3;
            4'd3: return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    initial begin
        int          acc;
        bit          have_prev;
        logic [3:0]  prev;
        logic [63:0] held;
        rst = 1'b1;
        in_valid = '0; in_a = '0; in_b = '0; in_ctrl = '0;
        out_ready = 4'hf; host_out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        rst = 1'b0;
        cyc();
        chk("post_rst_in_ready", 64'(in_ready), 64'h1f);

        // Local ADD
        offer(4, 64'd5, 64'd7, 16'h2201); cyc(); in_valid = '0; cyc();
        chk("add_valid", 64'(host_out_valid), 64'h1);
        chk("add_result", host_out_a, 64'd12);
        chk("add_ctrl", 64'(host_out_ctrl), 64'h2201);

        // Forwarding W -> E and W -> N
        offer(3, 64'hAA, 64'h0, 16'h5203); cyc(); in_valid = '0; cyc();
        chk("fwd_e_valid", 64'(out_valid[1]), 64'h1);
        chk("fwd_e_a", out_a[1], 64'hAA);
        chk("fwd_e_ctrl", 64'(out_ctrl[1]), 64'h5203);
        offer(3, 64'h55, 64'h0, 16'h2003); cyc(); in_valid = '0; cyc();
        chk("fwd_n_valid", 64'(out_valid[0]), 64'h1);
        chk("fwd_n_ctrl", 64'(out_ctrl[0]), 64'h2003);

        // MUL and SHR
        offer(4, 64'd3, 64'd4, 16'h2280); cyc(); in_valid = '0; cyc();
        chk("mul_result", host_out_a, MUL_EXP);
        offer(4, 64'h80, 64'd68, 16'h2260); cyc(); in_valid = '0; cyc();
        chk("shr_result", host_out_a, 64'h08);

        // Contention on E from N, S, W, host
        have_prev = 0; prev = '0;
        for (int c = 0; c < 12; c++) begin
            offer(0, 64'(c), 64'(c + 100), {8'h32, 4'd0, 4'(c)});
            offer(2, 64'(c), 64'(c + 200), {8'h32, 4'd2, 4'(c)});
            offer(3, 64'(c), 64'(c + 300), {8'h32, 4'd3, 4'(c)});
            offer(4, 64'(c), 64'(c + 400), {8'h32, 4'd4, 4'(c)});
            cyc();
            if (out_valid[1]) begin
                if (have_prev) chk("rr_order", 64'(out_ctrl[1][7:4]), 64'(rr_next(prev)));
                prev = out_ctrl[1][7:4];
                have_prev = 1;
            end
        end
        in_valid = '0;
        for (int c = 0; c < 20; c++) cyc();

        // Backpressure on E
        out_ready[1] = 1'b0;
        acc = 0;
        for (int n = 0; n < DEPTH + 2; n++) begin
            offer(3, 64'(256 + n), 64'(n), {8'h32, 4'd1, 4'(n)});
            if (in_ready[3]) acc++;
            cyc();
        end
        in_valid = '0;
        held = out_a[1];
        cyc(); cyc(); cyc();
        chk("bp_accepts", 64'(acc), 64'(DEPTH + 1));
        chk("bp_head", out_a[1], 64'h100);
        chk("bp_stable", out_a[1], held);
        chk("bp_in_ready_w", 64'(in_ready[3]), 64'h0);
        out_ready = 4'hf;
        for (int c = 0; c < 10; c++) cyc();

        // Reset mid-stream
        out_ready = 4'h0; host_out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            offer(0, 64'(c), 64'(c), 16'h3201);
            offer(2, 64'(c), 64'(c), 16'h2201);
            offer(3, 64'(c), 64'(c), 16'h1201);
            cyc();
        end
        in_valid = '0;
        rst = 1'b1;
        cyc();
        chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_host_valid", 64'(host_out_valid), 64'h0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'h0);
        rst = 1'b0; out_ready = 4'hf; host_out_ready = 1'b1;
        cyc();
        chk("after_rst_in_ready", 64'(in_ready), 64'h1f);
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("no_stale_out", 64'(out_valid), 64'h0);
            chk("no_stale_host", 64'(host_out_valid), 64'h0);
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            in_valid = 5'($urandom_range(0, 31));
            for (int p = 0; p < 5; p++) begin
                in_a[p] = {$urandom, $urandom};
                in_b[p] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 130)) : {$urandom, $urandom};
                in_ctrl[p] = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            end
            out_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
            host_out_ready = ($urandom_range(0, 4) != 0);
            cyc();
        end
        in_valid = '0; out_ready = 4'hf; host_out_ready = 1'b1;
        for (int c = 0; c < 30; c++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
